// File: rtl/encode_block.sv
// Polar encoder: splits a K-bit frame into N/P sub-blocks, inserts frozen zeros
// from a reliability ordering and applies the natural-order P-point polar transform.
module encode_block #(
    parameter int unsigned BITS = 8,
    parameter int unsigned N    = 2048,
    parameter int unsigned K    = 1024,
    parameter int unsigned P    = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                data [K],
    input  logic [$clog2(P):0]  sorted_indexes [P],
    output logic                out_valid,
    input  logic                out_ready,
    output logic                coded [N]
);
    localparam int unsigned BLOCKS       = N / P;
    localparam int unsigned LOG2P        = $clog2(P);
    localparam int unsigned BPB          = (K + BLOCKS - 1) / BLOCKS;
    localparam int unsigned ZEROS_NORMAL = P - BPB;
    localparam int unsigned ZEROS_LAST   = N - K - (BLOCKS - 1) * ZEROS_NORMAL;
    localparam int unsigned CNT_LAST     = K - (BLOCKS - 1) * BPB;
    localparam int unsigned BW           = (BLOCKS > 1) ? $clog2(BLOCKS) : 1;
    localparam int unsigned SW           = LOG2P;
    localparam int unsigned PW           = LOG2P;
    localparam int unsigned KW           = (K > 1) ? $clog2(K) : 1;
    localparam int unsigned NW           = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, STAGE, DONE} state_t;

    state_t            state, state_nx;
    logic [BW-1:0]     blk;
    logic [SW-1:0]     stage;
    logic [P-1:0]      work, u_load, x_stage, frozen;
    logic [K-1:0]      data_r;
    logic [LOG2P-1:0]  idx_r [P];
    logic              accept, last_blk, last_stage;
    logic              in_ready_nx, out_valid_nx;
    int unsigned       zc, cnt, base, m, step;
    logic              unused_bits;

    assign accept     = in_valid && in_ready;
    assign last_blk   = (blk == BW'(BLOCKS - 1));
    assign last_stage = (stage == SW'(LOG2P - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = LOAD;
            LOAD:    state_nx = STAGE;
            STAGE:   if (last_stage) state_nx = last_blk ? DONE : LOAD;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output decode, registered below so handshakes are glitch-free
    always_comb begin
        in_ready_nx  = (state_nx == IDLE);
        out_valid_nx = (state_nx == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            in_ready  <= in_ready_nx;
            out_valid <= out_valid_nx;
        end
    end

    // Frame capture so the inputs may change once accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_r <= '0;
            for (int i = 0; i < P; i++) idx_r[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < K; i++) data_r[i] <= data[i];
            for (int i = 0; i < P; i++) idx_r[i] <= sorted_indexes[i][LOG2P-1:0];
        end
    end

    // Sub-block assembly: freeze least-reliable positions, fill the rest in ascending order
    always_comb begin
        frozen = '0;
        u_load = '0;
        m      = 0;
        zc     = last_blk ? ZEROS_LAST : ZEROS_NORMAL;
        cnt    = last_blk ? CNT_LAST : BPB;
        base   = 32'(blk) * BPB;
        for (int j = 0; j < P; j++) begin
            if (32'(j) < zc) frozen[idx_r[P-1-j]] = 1'b1;
        end
        for (int i = 0; i < P; i++) begin
            if (!frozen[i]) begin
                if (m < cnt && base + m < K) u_load[i] = data_r[KW'(base + m)];
                m = m + 1;
            end
        end
    end

    // One butterfly stage of span 2^stage
    always_comb begin
        x_stage = work;
        step    = 32'(1) << stage;
        for (int i = 0; i < P; i++) begin
            if ((32'(i) & step) == 0) x_stage[i] = work[i] ^ work[PW'(32'(i) + step)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk   <= '0;
            stage <= '0;
            work  <= '0;
            for (int i = 0; i < N; i++) coded[i] <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) blk <= '0;
                LOAD: begin
                    work  <= u_load;
                    stage <= '0;
                end
                STAGE: begin
                    work <= x_stage;
                    if (last_stage) begin
                        for (int i = 0; i < P; i++)
                            coded[NW'(32'(blk) * P + 32'(i))] <= x_stage[i];
                        if (!last_blk) blk <= blk + BW'(1);
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // BITS and the top index bit exist only for parameter/port parity with the decoder
    always_comb begin
        unused_bits = ^BITS;
        for (int i = 0; i < P; i++) unused_bits = unused_bits ^ sorted_indexes[i][LOG2P];
    end

endmodule
